// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the multi-channel PWM block.
package pwm_pkg;

  // Default channel count and duty/period word width.
  localparam int STAGE_DEF  = 8;
  localparam int DWIDTH_DEF = 8;

  // Duty-set loader: waiting for a start word, or filling the shadow set.
  typedef enum logic {
    L_IDLE = 1'b0,
    L_LOAD = 1'b1
  } load_state_e;

  // Frame generator: halted with outputs low, or running frames.
  typedef enum logic {
    F_STOP = 1'b0,
    F_RUN  = 1'b1
  } frame_state_e;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: decides whether its output is high in the given frame cycle.
// Arithmetic is one bit wider than the word so that a frame length of
// 2**DWIDTH (period all ones) is representable.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic [DWIDTH-1:0] i_duty,
  input  logic [DWIDTH-1:0] i_cnt,
  input  logic [DWIDTH-1:0] i_period,
  input  logic              i_center,
  output logic              o_pwm
);

  logic [DWIDTH:0] w_duty;
  logic [DWIDTH:0] w_cnt;
  logic [DWIDTH:0] w_len;
  logic [DWIDTH:0] w_lead;
  logic [DWIDTH:0] w_stop;
  logic            w_full;

  assign w_duty = {1'b0, i_duty};
  assign w_cnt  = {1'b0, i_cnt};
  assign w_len  = {1'b0, i_period} + (DWIDTH+1)'(1);
  assign w_full = (w_duty >= w_len);

  // Centred pulse: idle cycles split with the odd one placed after the pulse.
  // Only meaningful when the duty is shorter than the frame.
  assign w_lead = (w_len - w_duty) >> 1;
  assign w_stop = w_lead + w_duty;

  // Select the window test for the current alignment mode.
  always_comb begin
    o_pwm = 1'b0;
    if (w_full) begin
      o_pwm = 1'b1;
    end else if (i_center) begin
      o_pwm = (w_cnt >= w_lead) && (w_cnt < w_stop);
    end else begin
      o_pwm = (w_cnt < w_duty);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a double-buffered duty set.
//
// Load FSM
//   state  | meaning
//   L_IDLE | waiting for a word flagged with start (others are dropped)
//   L_LOAD | filling shadow[1..STAGE-1]; start restarts at shadow[0]
//
// Frame FSM
//   state  | meaning
//   F_STOP | outputs held low, counter parked at 0
//   F_RUN  | counter sweeps 0..P; cycle 0 latches period/center/duties
//
// A complete shadow set raises pending and blocks further words until the
// next frame start copies it into the active duties.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int STAGE  = STAGE_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clkforcounter,
  input  logic              rst_n,
  input  logic              start,
  input  logic              data_valid,
  input  logic [DWIDTH-1:0] data,
  output logic              data_ready,
  input  logic              enable,
  input  logic [DWIDTH-1:0] period,
  input  logic              center,
  output logic [STAGE-1:0]  out,
  output logic              hsync,
  output logic              pending
);

  localparam int            IW       = (STAGE > 1) ? $clog2(STAGE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(STAGE - 1);

  // Loader
  load_state_e                  r_lstate;
  load_state_e                  w_lstate_nxt;
  logic [IW-1:0]                r_idx;
  logic [IW-1:0]                w_idx_nxt;
  logic [IW-1:0]                w_wr_sel;
  logic                         w_wr_en;
  logic                         w_pend_set;
  logic                         w_xfer;
  logic                         r_pending;
  logic [STAGE-1:0][DWIDTH-1:0] r_shadow;

  // Frame generator
  frame_state_e                 r_fstate;
  frame_state_e                 w_fstate_nxt;
  logic [DWIDTH-1:0]            r_cnt;
  logic [DWIDTH-1:0]            w_cnt_nxt;
  logic [DWIDTH-1:0]            r_period;
  logic [DWIDTH-1:0]            w_period_eff;
  logic                         r_center;
  logic                         w_center_eff;
  logic                         w_run;
  logic                         w_frame_start;
  logic                         w_swap;
  logic [STAGE-1:0][DWIDTH-1:0] r_active;
  logic [STAGE-1:0][DWIDTH-1:0] w_duty_eff;
  logic [STAGE-1:0]             w_pwm;
  logic [STAGE-1:0]             r_out;
  logic                         r_hsync;

  assign data_ready = !r_pending;
  assign pending    = r_pending;
  assign w_xfer     = data_valid && !r_pending;

  // Loader next state: where the accepted word goes and whether the set is done.
  always_comb begin
    w_lstate_nxt = r_lstate;
    w_idx_nxt    = r_idx;
    w_wr_en      = 1'b0;
    w_wr_sel     = '0;
    w_pend_set   = 1'b0;
    if (w_xfer) begin
      if (start) begin
        w_wr_en      = 1'b1;
        w_wr_sel     = '0;
        w_idx_nxt    = IW'(1);
        w_lstate_nxt = L_LOAD;
      end else if (r_lstate == L_LOAD) begin
        w_wr_en  = 1'b1;
        w_wr_sel = r_idx;
        if (r_idx == LAST_IDX) begin
          w_pend_set   = 1'b1;
          w_idx_nxt    = '0;
          w_lstate_nxt = L_IDLE;
        end else begin
          w_idx_nxt = r_idx + IW'(1);
        end
      end
    end
  end

  // Loader state register.
  always_ff @(posedge clkforcounter or negedge rst_n) begin
    if (!rst_n) begin
      r_lstate <= L_IDLE;
      r_idx    <= '0;
    end else begin
      r_lstate <= w_lstate_nxt;
      r_idx    <= w_idx_nxt;
    end
  end

  // Shadow storage and the pending flag that hands the set to the frame side.
  always_ff @(posedge clkforcounter or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_shadow[w_wr_sel] <= data;
      end
      if (w_pend_set) begin
        r_pending <= 1'b1;
      end else if (w_swap) begin
        r_pending <= 1'b0;
      end
    end
  end

  // On frame cycle 0 the compare must already see the values being latched,
  // so the first output cycle of a frame uses the new settings.
  assign w_run         = (r_fstate == F_RUN);
  assign w_frame_start = w_run && (r_cnt == '0);
  assign w_swap        = w_frame_start && r_pending;
  assign w_period_eff  = w_frame_start ? period : r_period;
  assign w_center_eff  = w_frame_start ? center : r_center;
  assign w_duty_eff    = w_swap ? r_shadow : r_active;

  // Frame next state and counter; a stop request waits for the frame to end.
  always_comb begin
    w_fstate_nxt = r_fstate;
    w_cnt_nxt    = '0;
    case (r_fstate)
      F_STOP: begin
        if (enable) begin
          w_fstate_nxt = F_RUN;
        end
      end
      F_RUN: begin
        if (r_cnt == w_period_eff) begin
          w_cnt_nxt = '0;
          if (!enable) begin
            w_fstate_nxt = F_STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt + DWIDTH'(1);
        end
      end
      default: begin
        w_fstate_nxt = F_STOP;
      end
    endcase
  end

  // Frame state, counter and the per-frame latched settings.
  always_ff @(posedge clkforcounter or negedge rst_n) begin
    if (!rst_n) begin
      r_fstate <= F_STOP;
      r_cnt    <= '0;
      r_period <= '0;
      r_center <= 1'b0;
      r_active <= '0;
    end else begin
      r_fstate <= w_fstate_nxt;
      r_cnt    <= w_cnt_nxt;
      if (w_frame_start) begin
        r_period <= period;
        r_center <= center;
      end
      if (w_swap) begin
        r_active <= r_shadow;
      end
    end
  end

  for (genvar gi = 0; gi < STAGE; gi++) begin : g_chan
    pwm_chan #(
      .DWIDTH(DWIDTH)
    ) u_chan (
      .i_duty  (w_duty_eff[gi]),
      .i_cnt   (r_cnt),
      .i_period(w_period_eff),
      .i_center(w_center_eff),
      .o_pwm   (w_pwm[gi])
    );
  end

  // Register outputs together so hsync and out describe the same frame cycle.
  always_ff @(posedge clkforcounter or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_hsync <= 1'b0;
    end else begin
      r_out   <= w_run ? w_pwm : '0;
      r_hsync <= w_frame_start;
    end
  end

  assign out   = r_out;
  assign hsync = r_hsync;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed-plus-random bench for pwm_multi against a frame-level model.
`timescale 1ns/1ps
module tb_pwm_multi;

  localparam int STAGE  = 8;
  localparam int DWIDTH = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              data_valid;
  logic [DWIDTH-1:0] data;
  logic              data_ready;
  logic              enable;
  logic [DWIDTH-1:0] period;
  logic              center;
  logic [STAGE-1:0]  out;
  logic              hsync;
  logic              pending;

  int n_checks = 0;
  int n_errors = 0;
  int exp_d    [STAGE];
  int cnt_hi   [STAGE];
  int first_hi [STAGE];
  int last_hi  [STAGE];

  always #5 clk = ~clk;

  pwm_multi #(
    .STAGE (STAGE),
    .DWIDTH(DWIDTH)
  ) dut (
    .clkforcounter(clk),
    .rst_n        (rst_n),
    .start        (start),
    .data_valid   (data_valid),
    .data         (data),
    .data_ready   (data_ready),
    .enable       (enable),
    .period       (period),
    .center       (center),
    .out          (out),
    .hsync        (hsync),
    .pending      (pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Output level of one channel in frame cycle k of a frame of p+1 cycles.
  function automatic bit model_bit(int d, int p, bit c, int k);
    int len;
    int lead;
    len = p + 1;
    if (d >= len) return 1'b1;
    if (d == 0) return 1'b0;
    if (!c) return (k < d);
    lead = (len - d) / 2;
    return (k >= lead) && (k < lead + d);
  endfunction

  function automatic logic [STAGE-1:0] model_vec(int p, bit c, int k);
    logic [STAGE-1:0] v;
    v = '0;
    for (int i = 0; i < STAGE; i++) v[i] = model_bit(exp_d[i], p, c, k);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input bit st, input int w);
    start      = st;
    data_valid = 1'b1;
    data       = DWIDTH'(w);
    tick();
    start      = 1'b0;
    data_valid = 1'b0;
  endtask

  task automatic load_set(input int w [STAGE]);
    for (int i = 0; i < STAGE; i++) send_word(i == 0, w[i]);
  endtask

  task automatic wait_hsync(input int budget, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (hsync !== 1'b1 && waited < budget);
    check("hsync_seen", 32'(hsync), 1);
  endtask

  // Current sample must be frame cycle 0; checks the whole frame cycle by cycle.
  task automatic check_frame(input int p, input bit c, input string tag);
    for (int i = 0; i < STAGE; i++) begin
      cnt_hi[i]   = 0;
      first_hi[i] = -1;
      last_hi[i]  = -1;
    end
    for (int k = 0; k <= p; k++) begin
      if (k > 0) tick();
      check($sformatf("%s_out_k%0d", tag, k), 32'(out), 32'(model_vec(p, c, k)));
      check($sformatf("%s_hsync_k%0d", tag, k), 32'(hsync), 32'(k == 0));
      for (int i = 0; i < STAGE; i++) begin
        if (out[i] === 1'b1) begin
          cnt_hi[i]++;
          if (first_hi[i] < 0) first_hi[i] = k;
          last_hi[i] = k;
        end
      end
    end
  endtask

  initial begin
    int set_a [STAGE];
    int req_ff[STAGE];
    int req_0f[STAGE];
    int w     [STAGE];
    int zeros [STAGE];
    int waited;

    set_a  = '{8'h00, 8'h01, 8'h10, 8'h40, 8'h80, 8'hFE, 8'hFF, 8'h7F};
    req_ff = '{0, 1, 16, 64, 128, 254, 255, 127};
    req_0f = '{0, 1, 16, 16, 16, 16, 16, 16};
    zeros  = '{default: 0};

    rst_n = 1'b0; start = 1'b0; data_valid = 1'b0; data = '0;
    enable = 1'b0; period = '0; center = 1'b0;
    #7;
    check("rst_out",     32'(out), 0);
    check("rst_hsync",   32'(hsync), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_ready",   32'(data_ready), 1);
    #5 rst_n = 1'b1;
    tick();
    check("idle_out", 32'(out), 0);

    // Reference set, 256-cycle frames, left aligned.
    load_set(set_a);
    check("a_pending", 32'(pending), 1);
    check("a_ready",   32'(data_ready), 0);
    period = 8'hFF; center = 1'b0; enable = 1'b1;
    exp_d = set_a;
    wait_hsync(8, waited);
    check("first_frame_latency", 32'(waited), 2);
    check_frame(255, 1'b0, "a_ff");
    for (int i = 0; i < STAGE; i++) check($sformatf("a_ff_cnt%0d", i), 32'(cnt_hi[i]), 32'(req_ff[i]));
    check("a_swap_pending", 32'(pending), 0);
    check("a_swap_ready",   32'(data_ready), 1);

    // Period change inside a frame only takes effect on the next one.
    tick();
    check("a2_hsync", 32'(hsync), 1);
    period = 8'h0F;
    wait_hsync(300, waited);
    check("a2_len_kept", 32'(waited), 256);
    check_frame(15, 1'b0, "a_0f_1");
    wait_hsync(4, waited);
    check("a_0f_gap", 32'(waited), 1);
    check_frame(15, 1'b0, "a_0f_2");
    for (int i = 0; i < STAGE; i++) check($sformatf("a_0f_cnt%0d", i), 32'(cnt_hi[i]), 32'(req_0f[i]));

    // Centre alignment, P=9.
    tick();
    check("b_pre_hsync", 32'(hsync), 1);
    period = 8'h09; center = 1'b1;
    w[0] = 4; w[1] = 3;
    for (int i = 2; i < STAGE; i++) w[i] = int'($urandom_range(0, 11));
    load_set(w);
    check("b_pending", 32'(pending), 1);
    wait_hsync(20, waited);
    check("b_len_kept", 32'(waited), 8);
    exp_d = w;
    check_frame(9, 1'b1, "b_ctr");
    check("b_d4_first", 32'(first_hi[0]), 3);
    check("b_d4_last",  32'(last_hi[0]), 6);
    check("b_d3_first", 32'(first_hi[1]), 3);
    check("b_d3_last",  32'(last_hi[1]), 5);
    check("b_pending_clr", 32'(pending), 0);

    // New set loaded mid-frame: old duties hold until the next hsync.
    tick();
    check("c_pre_hsync", 32'(hsync), 1);
    period = 8'h3F; center = 1'b0;
    wait_hsync(20, waited);
    check("c_len_kept", 32'(waited), 10);
    check("c_k0_out", 32'(out), 32'(model_vec(63, 1'b0, 0)));
    for (int i = 0; i < STAGE; i++) w[i] = int'($urandom_range(0, 70));
    load_set(w);
    check("c_pending", 32'(pending), 1);
    check("c_ready",   32'(data_ready), 0);
    for (int k = 9; k <= 63; k++) begin
      tick();
      check($sformatf("c_old_k%0d", k), 32'(out), 32'(model_vec(63, 1'b0, k)));
    end
    tick();
    exp_d = w;
    check_frame(63, 1'b0, "c_new");
    check("c_pending_clr", 32'(pending), 0);
    check("c_ready_set",   32'(data_ready), 1);

    // Words without start are dropped; a restart discards a partial set.
    send_word(1'b0, 8'h55);
    send_word(1'b0, 8'h66);
    check("d_junk_pending", 32'(pending), 0);
    send_word(1'b1, 8'hA1);
    send_word(1'b0, 8'hA2);
    send_word(1'b0, 8'hA3);
    for (int i = 0; i < STAGE; i++) w[i] = int'($urandom_range(0, 70));
    w[0] = 8'h30;
    for (int i = 0; i < STAGE; i++) begin
      send_word(i == 0, w[i]);
      if (i == STAGE - 2) check("d_not_done", 32'(pending), 0);
    end
    check("d_done", 32'(pending), 1);
    wait_hsync(80, waited);
    exp_d = w;
    check_frame(63, 1'b0, "d_new");

    // Enable dropped in frame cycle 0: frame completes, then outputs stay low.
    tick();
    enable = 1'b0;
    check_frame(63, 1'b0, "e_last");
    for (int j = 0; j < 6; j++) begin
      tick();
      check($sformatf("e_stop_out%0d", j),   32'(out), 0);
      check($sformatf("e_stop_hsync%0d", j), 32'(hsync), 0);
    end

    // Asynchronous reset in the middle of a frame with a set pending.
    enable = 1'b1;
    wait_hsync(8, waited);
    check("f_restart_latency", 32'(waited), 2);
    for (int i = 0; i < STAGE; i++) w[i] = int'($urandom_range(0, 70));
    load_set(w);
    check("f_pending", 32'(pending), 1);
    tick();
    tick();
    check("f_pre_rst", 32'(out), 32'(model_vec(63, 1'b0, 10)));
    rst_n = 1'b0;
    #1;
    check("f_rst_out",     32'(out), 0);
    check("f_rst_hsync",   32'(hsync), 0);
    check("f_rst_pending", 32'(pending), 0);
    check("f_rst_ready",   32'(data_ready), 1);
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick();
      check($sformatf("f_quiet_out%0d", j),   32'(out), 0);
      check($sformatf("f_quiet_hsync%0d", j), 32'(hsync), 0);
    end
    enable = 1'b1;
    period = 8'h3F;
    wait_hsync(8, waited);
    check("f_post_latency", 32'(waited), 2);
    exp_d = zeros;
    check_frame(63, 1'b0, "f_zero");

    // Set completing on the frame-start cycle waits one more frame.
    tick();
    for (int j = 0; j < 56; j++) tick();
    for (int i = 0; i < STAGE; i++) w[i] = int'($urandom_range(1, 70));
    load_set(w);
    check("g_pending_edge", 32'(pending), 1);
    check_frame(63, 1'b0, "g_old");
    tick();
    check("g_pending_clr", 32'(pending), 0);
    exp_d = w;
    check_frame(63, 1'b0, "g_new");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
